// File: rtl/mul_sched_pkg.sv
// Shared types, sizing constants and the lane-count clamp for the multiplier lane-array sequencer.
package mul_sched_pkg;

    localparam int LANES = 100;
    localparam int W     = 12;
    localparam int GAP_W = 8;
    localparam int TMO   = 1024;
    localparam int CNT_W = 16;
    localparam int IDX_W = 7;
    localparam int TMO_W = $clog2(TMO);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT,
        DONE
    } state_t;

    // A requested count of 0 still runs one lane; oversize requests saturate at the array size.
    function automatic logic [IDX_W-1:0] clamp_lanes(input logic [IDX_W-1:0] req);
        if (req == '0)
            return IDX_W'(1);
        else if (req > IDX_W'(LANES))
            return IDX_W'(LANES);
        else
            return req;
    endfunction

endpackage

// File: rtl/mul_done_tracker.sv
// Tracks which lanes have been started and which started lanes have reported done.
module mul_done_tracker
    import mul_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [LANES-1:0] lane_start,
    input  logic [LANES-1:0] lane_done,
    input  logic [IDX_W-1:0] n_active,
    output logic             all_done
);

    logic [LANES-1:0] started_mask;
    logic [LANES-1:0] done_seen;
    logic [LANES-1:0] done_now;
    logic [LANES-1:0] active_mask;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            active_mask[i] = (IDX_W'(i) < n_active);
    end

    // A done arriving in the same cycle as its lane's start pulse still counts.
    assign done_now = lane_done & (started_mask | lane_start);
    assign all_done = &(done_seen | done_now | ~active_mask);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            started_mask <= '0;
            done_seen    <= '0;
        end else begin
            started_mask <= started_mask | lane_start;
            done_seen    <= done_seen | done_now;
        end
    end

endmodule

// File: rtl/mul_array_sched.sv
// Latches one operand pair, issues staggered per-lane start pulses and waits for all lanes to finish.
module mul_array_sched
    import mul_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [6:0]       cfg_lanes,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             trig,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    output logic [LANES-1:0] lane_start,
    input  logic [LANES-1:0] lane_done,
    output logic             busy,
    output logic             dvld,
    output logic             err_timeout,
    output logic [CNT_W-1:0] run_cycles,
    output logic             gpio_startn,
    output logic             gpio_exec
);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [GAP_W-1:0] gcnt, gcnt_d;
    logic [TMO_W-1:0] tcnt, tcnt_d;
    logic [IDX_W-1:0] lanes_q;
    logic [GAP_W-1:0] gap_q;
    logic             timeout_hit;
    logic             all_done;
    logic             accept;

    assign accept      = (state == IDLE) && trig;
    assign lane_start  = (state == ISSUE) ? (LANES'(1) << idx) : '0;
    assign busy        = (state == ISSUE) || (state == GAP) || (state == WAIT);
    assign gpio_exec   = busy;
    assign gpio_startn = !((state == ISSUE) || (state == GAP));
    assign dvld        = (state == DONE);

    mul_done_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .lane_start (lane_start),
        .lane_done  (lane_done),
        .n_active   (lanes_q),
        .all_done   (all_done)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d     = state;
        idx_d       = idx;
        gcnt_d      = gcnt;
        tcnt_d      = tcnt;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                if (idx == lanes_q - IDX_W'(1)) begin
                    state_d = WAIT;
                    tcnt_d  = '0;
                end else if (gap_q == '0) begin
                    idx_d = idx + IDX_W'(1);
                end else begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end
            GAP: begin
                if (gcnt == GAP_W'(1)) begin
                    state_d = ISSUE;
                    idx_d   = idx + IDX_W'(1);
                end else begin
                    gcnt_d = gcnt - GAP_W'(1);
                end
            end
            WAIT: begin
                if (all_done) begin
                    state_d = DONE;
                end else if (tcnt == TMO_W'(TMO - 1)) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end else begin
                    tcnt_d = tcnt + TMO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            gcnt        <= '0;
            tcnt        <= '0;
            lanes_q     <= IDX_W'(LANES);
            gap_q       <= '0;
            a_out       <= '0;
            b_out       <= '0;
            err_timeout <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            gcnt  <= gcnt_d;
            tcnt  <= tcnt_d;
            if (state == IDLE && cfg_wr) begin
                lanes_q <= clamp_lanes(cfg_lanes);
                gap_q   <= cfg_gap;
            end
            if (accept) begin
                a_out       <= a_in;
                b_out       <= b_in;
                err_timeout <= 1'b0;
                run_cycles  <= '0;
            end else if (state != IDLE && run_cycles != '1) begin
                run_cycles <= run_cycles + CNT_W'(1);
            end
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_array_sched.sv
// Self-checking bench for mul_array_sched: directed scenarios plus randomized runs against a timing model.
module tb_mul_array_sched;
    import mul_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_wr;
    logic [6:0]       cfg_lanes;
    logic [GAP_W-1:0] cfg_gap;
    logic             trig;
    logic [W-1:0]     a_in, b_in;
    logic [W-1:0]     a_out, b_out;
    logic [LANES-1:0] lane_start;
    logic [LANES-1:0] lane_done;
    logic             busy, dvld, err_timeout;
    logic [CNT_W-1:0] run_cycles;
    logic             gpio_startn, gpio_exec;

    int passes = 0;
    int total  = 0;
    int done_at [LANES];
    int spur_at [LANES];
    int m_lanes = LANES;
    int m_gap   = 0;

    mul_array_sched dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_lanes   (cfg_lanes),
        .cfg_gap     (cfg_gap),
        .trig        (trig),
        .a_in        (a_in),
        .b_in        (b_in),
        .a_out       (a_out),
        .b_out       (b_out),
        .lane_start  (lane_start),
        .lane_done   (lane_done),
        .busy        (busy),
        .dvld        (dvld),
        .err_timeout (err_timeout),
        .run_cycles  (run_cycles),
        .gpio_startn (gpio_startn),
        .gpio_exec   (gpio_exec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int clamp_model(input int v);
        if (v == 0) return 1;
        if (v > LANES) return LANES;
        return v;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < LANES; i++) begin
            done_at[i] = -1;
            spur_at[i] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from trig to completion. Cycle c counts from the trig cycle (c = 0).
    task automatic run(input string name, input bit do_cfg, input int n_cfg, input int g_cfg,
                       input bit pokes);
        logic [W-1:0]     a, b;
        logic [LANES-1:0] exp_ls;
        int n, g, e, last, d, s, k;
        bit never, exp_err;
        a = W'($urandom);
        b = W'($urandom);
        a_in = a;
        b_in = b;
        if (do_cfg) begin
            cfg_wr    = 1'b1;
            cfg_lanes = 7'(n_cfg);
            cfg_gap   = GAP_W'(g_cfg);
            m_lanes   = clamp_model(n_cfg);
            m_gap     = g_cfg;
        end
        trig = 1'b1;

        n = m_lanes;
        g = m_gap;
        e = 2 + (n - 1) * (g + 1);
        last = e;
        never = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = 1 + i * (g + 1);
            if (done_at[i] >= s) last = (done_at[i] > last) ? done_at[i] : last;
            else never = 1'b1;
        end
        if (never || (last - e) > TMO - 1) begin
            d = e + TMO;
            exp_err = 1'b1;
        end else begin
            d = last + 1;
            exp_err = 1'b0;
        end

        for (int c = 1; c <= d; c++) begin
            tick();
            trig   = 1'b0;
            cfg_wr = 1'b0;
            if (pokes && c == 2) begin
                trig      = 1'b1;
                cfg_wr    = 1'b1;
                cfg_lanes = 7'd1;
                cfg_gap   = '0;
                a_in      = ~a;
            end
            if (pokes && c == d) trig = 1'b1;
            for (int i = 0; i < LANES; i++)
                lane_done[i] = (done_at[i] == c) || (spur_at[i] == c);
            exp_ls = '0;
            k = (c - 1) / (g + 1);
            if ((c - 1) % (g + 1) == 0 && k < n) exp_ls[k] = 1'b1;
            check({name, " lane_start"}, lane_start, exp_ls);
            check({name, " gpio_startn"}, gpio_startn, (c < e) ? 1'b0 : 1'b1);
            check({name, " dvld"}, dvld, (c == d) ? 1'b1 : 1'b0);
            if (c < d) begin
                check({name, " busy"}, busy, 1'b1);
                check({name, " gpio_exec"}, gpio_exec, 1'b1);
            end
            if (c == 1) check({name, " err_cleared"}, err_timeout, 1'b0);
        end

        tick();
        trig      = 1'b0;
        cfg_wr    = 1'b0;
        lane_done = '0;
        check({name, " post busy"}, busy, 1'b0);
        check({name, " post dvld"}, dvld, 1'b0);
        check({name, " run_cycles"}, run_cycles, 128'(d));
        check({name, " err_timeout"}, err_timeout, exp_err);
        check({name, " a_out"}, a_out, a);
        check({name, " b_out"}, b_out, b);
        if (pokes) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                check({name, " idle start"}, lane_start, '0);
                check({name, " idle busy"}, busy, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_lanes = '0; cfg_gap = '0; trig = 1'b0;
        a_in = '0; b_in = '0; lane_done = '0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1;
        check("rst a_out", a_out, '0);
        check("rst b_out", b_out, '0);
        check("rst lane_start", lane_start, '0);
        check("rst busy", busy, 1'b0);
        check("rst dvld", dvld, 1'b0);
        check("rst err", err_timeout, 1'b0);
        check("rst run_cycles", run_cycles, '0);
        check("rst gpio_startn", gpio_startn, 1'b1);
        check("rst gpio_exec", gpio_exec, 1'b0);
        rst = 1'b0;
        tick();

        // Basic: four lanes, no gap, all done in cycle 8.
        clear_sched();
        for (int i = 0; i < 4; i++) done_at[i] = 8;
        run("basic", 1'b1, 4, 0, 1'b0);

        // Staggered starts with a gap of two; lanes >= 3 pulse done but are never started.
        clear_sched();
        for (int i = 0; i < 6; i++) done_at[i] = 9 + i;
        run("gap2", 1'b1, 3, 2, 1'b0);

        // Lane 1 never finishes: timeout, then the next run clears the error.
        clear_sched();
        done_at[0] = 3;
        run("timeout", 1'b1, 2, 1, 1'b0);
        clear_sched();
        done_at[0] = 4; done_at[1] = 6;
        run("after_tmo", 1'b0, 2, 1, 1'b0);

        // Early done on lane 5 before its start must be ignored.
        clear_sched();
        for (int i = 0; i < 8; i++) done_at[i] = 31;
        spur_at[5] = 10;
        done_at[5] = 40;
        run("early_done", 1'b1, 8, 3, 1'b0);

        // trig/cfg_wr while busy and trig on the DONE cycle are ignored.
        clear_sched();
        for (int i = 0; i < 5; i++) done_at[i] = 12;
        run("busy_pokes", 1'b1, 5, 1, 1'b1);

        // Reset while in GAP after two of five starts.
        cfg_wr = 1'b1; cfg_lanes = 7'd5; cfg_gap = GAP_W'(3);
        a_in = W'(12'hABC); b_in = W'(12'h321); trig = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            trig = 1'b0; cfg_wr = 1'b0;
            check("rst_mid start", lane_start,
                  (c == 1) ? 128'h1 : ((c == 5) ? 128'h2 : 128'h0));
            if (c == 6) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        check("rst_mid start", lane_start, '0);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid startn", gpio_startn, 1'b1);
        check("rst_mid dvld", dvld, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_mid quiet start", lane_start, '0);
            check("rst_mid quiet dvld", dvld, 1'b0);
        end
        m_lanes = LANES;
        m_gap   = 0;
        clear_sched();
        for (int i = 0; i < LANES; i++) done_at[i] = 1 + i + int'($urandom_range(0, 5));
        run("cfg_after_rst", 1'b0, 0, 0, 1'b0);

        // Lane-count clamping.
        clear_sched();
        done_at[0] = 3; done_at[1] = 3;
        run("lanes0", 1'b1, 0, 0, 1'b0);
        clear_sched();
        for (int i = 0; i < LANES; i++) done_at[i] = 1 + i + int'($urandom_range(0, 3));
        run("lanes127", 1'b1, 127, 0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int n, g, s;
            n = int'($urandom_range(1, 12));
            g = int'($urandom_range(0, 4));
            clear_sched();
            for (int i = 0; i < n + 2; i++) begin
                s = 1 + i * (g + 1);
                done_at[i] = s + int'($urandom_range(0, 15));
                if (s > 1 && $urandom_range(0, 3) == 0) spur_at[i] = int'($urandom_range(1, s - 1));
            end
            run("random", 1'b1, n, g, (r % 3) == 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
